// File: rtl/static_buffer_drain.sv
// static_buffer_drain: pops words from a static_buffer and emits them as DMA write bursts
module static_buffer_drain #(
  parameter int WORD_WIDTH = 64,
  parameter int MAX_BURST  = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int DEBUG      = 1,
  localparam int LW = $clog2(MAX_BURST) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  total_words,
  output logic                  busy,
  output logic                  done,
  input  logic [WORD_WIDTH-1:0] src_data,
  input  logic                  src_empty,
  output logic                  src_ready,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [LW-1:0]         wr_req_len,
  output logic                  wr_data_valid,
  input  logic                  wr_data_ready,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  wr_data_last
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [LW-1:0]         cur_len;
  logic [LW-1:0]         fetch_left;
  logic [LW-1:0]         pop_idx;
  logic                  last_hs;
  assign busy         = state != S_IDLE;
  assign done         = state == S_DONE;
  assign wr_req_valid = state == S_REQ;
  assign wr_req_addr  = addr;
  assign wr_req_len   = remaining >= CNT_WIDTH'(MAX_BURST) ? LW'(MAX_BURST) : LW'(remaining);
  assign src_ready    = state == S_DATA && !src_empty && fetch_left != '0 && (!wr_data_valid || wr_data_ready);
  assign last_hs      = wr_data_valid && wr_data_ready && wr_data_last;
  // control: burst slicing, address advance and per-burst pop accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      remaining  <= '0;
      cur_len    <= '0;
      fetch_left <= '0;
      pop_idx    <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        state     <= total_words == '0 ? S_DONE : S_REQ;
        addr      <= base_addr;
        remaining <= total_words;
      end
    end else if (state == S_REQ) begin
      if (wr_req_ready) begin
        state      <= S_DATA;
        remaining  <= remaining - CNT_WIDTH'(wr_req_len);
        addr       <= addr + ADDR_WIDTH'(wr_req_len) * ADDR_WIDTH'(WORD_WIDTH / 8);
        cur_len    <= wr_req_len;
        fetch_left <= wr_req_len;
        pop_idx    <= '0;
      end
    end else if (state == S_DATA) begin
      if (src_ready) begin
        fetch_left <= fetch_left - LW'(1);
        pop_idx    <= pop_idx + LW'(1);
      end
      if (last_hs) state <= remaining == '0 ? S_DONE : S_REQ;
    end else begin
      state <= S_IDLE;
    end
  end
  // one-entry output register: loads on pop, drops valid on accept without refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_data       <= '0;
      wr_data_valid <= 1'b0;
      wr_data_last  <= 1'b0;
    end else if (src_ready) begin
      wr_data       <= src_data;
      wr_data_valid <= 1'b1;
      wr_data_last  <= pop_idx == cur_len - LW'(1);
    end else if (wr_data_ready) begin
      wr_data_valid <= 1'b0;
      wr_data_last  <= 1'b0;
    end
  end
  if (DEBUG != 0) begin : g_dbg
    // pops only ever happen in DATA against a non-empty buffer
    always_ff @(posedge clk) begin
      assert (!(src_ready && (src_empty || state != S_DATA)));
    end
  end
endmodule

// File: tb/tb_static_buffer_drain.sv
// tb_static_buffer_drain: scoreboard bench for the buffer-to-DMA burst drain
module tb_static_buffer_drain;
  localparam int W = 64, MB = 16, AW = 32, CW = 16, LW = 5;
  logic clk = 1'b0, rst, start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] total_words;
  logic busy, done, src_empty, src_ready;
  logic [W-1:0] src_data, wr_data;
  logic wr_req_valid, wr_req_ready, wr_data_valid, wr_data_ready, wr_data_last;
  logic [AW-1:0] wr_req_addr;
  logic [LW-1:0] wr_req_len;
  static_buffer_drain dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_words(total_words),
    .busy(busy), .done(done), .src_data(src_data), .src_empty(src_empty), .src_ready(src_ready),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_len(wr_req_len), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .wr_data(wr_data), .wr_data_last(wr_data_last)
  );
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0;
  int done_cnt = 0, beat_cnt = 0, req_cnt = 0, viol = 0, beat_i = 0, cur_len = 0;
  logic [31:0] seq = 32'd0;
  logic [W-1:0] exp_q[$];
  logic [AW+LW-1:0] req_q[$];
  logic pstall = 1'b0, prstall = 1'b0;
  logic [W-1:0] pdata;
  logic [AW+LW-1:0] preq, r;
  assign src_data = {seq ^ 32'hA5A5_5A5A, seq};
  always @(posedge clk) if (src_ready && !src_empty) seq <= seq + 32'd1;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      pstall = 1'b0;
      prstall = 1'b0;
    end else begin
      if (src_ready && (src_empty || wr_req_valid || !busy)) viol++;
      if (pstall && !(wr_data_valid && wr_data === pdata)) viol++;
      if (prstall && !(wr_req_valid && {wr_req_addr, wr_req_len} === preq)) viol++;
      if (wr_req_valid && wr_req_ready) begin
        req_cnt++;
        if (req_q.size() == 0) begin
          chk("req_extra", 1, 0);
          cur_len = int'(wr_req_len);
        end else begin
          r = req_q.pop_front();
          chk("req_addr", 64'(wr_req_addr), 64'(r[AW+LW-1:LW]));
          chk("req_len", 64'(wr_req_len), 64'(r[LW-1:0]));
          cur_len = int'(r[LW-1:0]);
        end
        beat_i = 0;
      end
      if (wr_data_valid && wr_data_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) chk("beat_extra", 1, 0);
        else chk("beat_data", wr_data, exp_q.pop_front());
        chk("beat_last", 64'(wr_data_last), 64'(beat_i == cur_len - 1));
        beat_i++;
      end
      if (done) done_cnt++;
      if (src_ready && !src_empty) exp_q.push_back(src_data);
      pstall = wr_data_valid && !wr_data_ready;
      pdata = wr_data;
      prstall = wr_req_valid && !wr_req_ready;
      preq = {wr_req_addr, wr_req_len};
    end
  end
  task automatic push_reqs(logic [AW-1:0] b, int total);
    logic [AW-1:0] a = b;
    int rem = total, l;
    while (rem > 0) begin
      l = rem > MB ? MB : rem;
      req_q.push_back({a, LW'(l)});
      a = a + AW'(l * (W / 8));
      rem -= l;
    end
  endtask
  task automatic drive(int mode, int n, bit pulse);
    src_empty = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    wr_data_ready = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
    wr_req_ready = mode == 2 ? n >= 10 : 1'b1;
    start = pulse && n == 5;
    if (start) begin
      base_addr = '0;
      total_words = CW'(7);
    end
  endtask
  task automatic outs_zero(string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_reqv"}, 64'({wr_req_valid, wr_req_addr, wr_req_len}), 0);
    chk({tag, "_datv"}, 64'({wr_data_valid, wr_data_last, src_ready}), 0);
    chk({tag, "_data"}, wr_data, 0);
  endtask
  task automatic run(logic [AW-1:0] b, int total, int mode, bit pulse, string tag);
    int d0 = done_cnt, n = 0;
    push_reqs(b, total);
    drive(mode, 0, 1'b0);
    base_addr = b;
    total_words = CW'(total);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (total != 0) chk({tag, "_reqv_t1"}, 64'(wr_req_valid), 1);
    else chk({tag, "_zero_t1"}, 64'({done, wr_req_valid, src_ready}), 64'(3'b100));
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      #1 n++;
      if (mode == 2 && n <= 10) begin
        chk({tag, "_stall_reqv"}, 64'(wr_req_valid), 1);
        chk({tag, "_stall_addr"}, 64'({wr_req_addr, wr_req_len}), 64'({b, LW'(MB)}));
        chk({tag, "_stall_pop"}, 64'(src_ready), 0);
      end
      drive(mode, n, pulse);
    end
    chk({tag, "_timeout"}, 64'(n < 3000), 1);
    drive(0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk({tag, "_busy_after"}, 64'(busy), 0);
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 1);
    chk({tag, "_beats_left"}, 64'(exp_q.size()), 0);
    chk({tag, "_reqs_left"}, 64'(req_q.size()), 0);
  endtask
  initial begin
    int b0, r0, n;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    total_words = '0;
    src_empty = 1'b1;
    wr_req_ready = 1'b1;
    wr_data_ready = 1'b1;
    #3 outs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    b0 = beat_cnt;
    r0 = req_cnt;
    run(32'h0000_1000, 40, 0, 1'b0, "t1");
    chk("t1_beats", 64'(beat_cnt - b0), 40);
    chk("t1_reqs", 64'(req_cnt - r0), 3);
    r0 = req_cnt;
    run(32'h0000_2000, 0, 0, 1'b0, "t2");
    chk("t2_reqs", 64'(req_cnt - r0), 0);
    b0 = beat_cnt;
    run(32'h0000_3000, 20, 1, 1'b0, "t3");
    chk("t3_beats", 64'(beat_cnt - b0), 20);
    run(32'h0000_4000, 24, 2, 1'b0, "t4");
    b0 = beat_cnt;
    push_reqs(32'h0000_5000, 16);
    base_addr = 32'h0000_5000;
    total_words = CW'(16);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (beat_cnt < b0 + 5 && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("t5_timeout", 64'(n < 200), 1);
    #1 rst = 1'b1;
    #1 outs_zero("t5_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    req_q.delete();
    r0 = req_cnt;
    b0 = done_cnt;
    repeat (5) @(posedge clk);
    #1 chk("t5_no_resume", 64'({busy, 8'(req_cnt - r0), 8'(done_cnt - b0)}), 0);
    run(32'h0000_6000, 4, 0, 1'b0, "t5b");
    r0 = req_cnt;
    run(32'hFFFF_FFC0, 32, 0, 1'b1, "t6");
    chk("t6_reqs", 64'(req_cnt - r0), 2);
    chk("invariants", 64'(viol), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
